// File: rtl/fp32_pkg.sv
// Shared FP32 constants, converter state encoding and field packing helper
// for the integer-to-float side of the FP pipeline.
package fp32_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;

  // Exponent of a value whose leading one sits at bit 31 of the magnitude.
  localparam logic [FP32_EXP_W-1:0] INT_EXP_MAX = FP32_EXP_W'(FP32_BIAS + 31);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } conv_state_e;

  function automatic logic [31:0] fp32_pack(input logic                   sign,
                                            input logic [FP32_EXP_W-1:0]  exponent,
                                            input logic [FP32_FRAC_W-1:0] frac);
    return {sign, exponent, frac};
  endfunction

endpackage

// File: rtl/int_to_fp32_if.sv
// Operand/result handshake bundle of the int_to_fp32 converter.
interface int_to_fp32_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  // The converter itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );

endinterface

// File: rtl/norm_shift_step.sv
// Bounded left shift: moves the leading one of mag up by at most SHIFT_STEP
// bits per call, never past bit 31.
module norm_shift_step #(
  parameter int SHIFT_STEP = 1
) (
  input  logic [31:0] mag,
  output logic [31:0] shifted,
  output logic [3:0]  k
);

  logic found;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    found = 1'b0;
    k     = '0;
    // Count leading zeros only inside the top SHIFT_STEP bits.
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!found) begin
        if (mag[31-i]) found = 1'b1;
        else           k     = k + 4'd1;
      end
    end
    shifted = mag << k;
  end

endmodule

// File: rtl/int_to_fp32.sv
// Iterative signed int32 -> IEEE-754 single converter, round-to-nearest-even,
// normalised by a multi-cycle bounded shift loop; one operand in flight.
module int_to_fp32
  import fp32_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  int_to_fp32_if.slave  bus
);

  conv_state_e            state_q, state_d;
  logic                   sgn_q, sgn_d;
  logic [31:0]            mag_q, mag_d;
  logic [FP32_EXP_W-1:0]  exp_q, exp_d;
  logic [31:0]            data_q, data_d;
  logic                   inexact_q, inexact_d;

  logic [31:0]            in_mag;
  logic [31:0]            shifted;
  logic [3:0]             shift_k;

  logic [FP32_FRAC_W-1:0] frac_raw;
  logic                   guard, sticky, round_up;
  logic [FP32_FRAC_W:0]   frac_sum;
  logic [FP32_EXP_W-1:0]  exp_rnd;

  norm_shift_step #(.SHIFT_STEP(SHIFT_STEP)) u_shift (
    .mag     (mag_q),
    .shifted (shifted),
    .k       (shift_k)
  );

  // Two's-complement negate; 32'h80000000 maps onto itself, which is the right magnitude.
  assign in_mag = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;

  // Leading one is at mag_q[31] in ROUND, so it is the hidden bit.
  assign frac_raw = mag_q[30:8];
  assign guard    = mag_q[7];
  assign sticky   = |mag_q[6:0];
  assign round_up = guard & (sticky | frac_raw[0]);
  assign frac_sum = {1'b0, frac_raw} + {{FP32_FRAC_W{1'b0}}, round_up};
  // A carry out of the fraction leaves frac_sum[22:0] at zero; only the exponent moves.
  assign exp_rnd  = exp_q + {{(FP32_EXP_W-1){1'b0}}, frac_sum[FP32_FRAC_W]};

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    data_d    = data_q;
    inexact_d = inexact_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sgn_d = bus.in_data[31];
          mag_d = in_mag;
          exp_d = INT_EXP_MAX;
          if (in_mag == 32'd0) begin
            // Zero is always +0, whatever the sign bit said.
            data_d    = 32'h0;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = shifted;
          exp_d = exp_q - {{(FP32_EXP_W-4){1'b0}}, shift_k};
        end
      end

      ROUND: begin
        data_d    = fp32_pack(sgn_q, exp_rnd, frac_sum[FP32_FRAC_W-1:0]);
        inexact_d = guard | sticky;
        state_d   = DONE;
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      data_q    <= '0;
      inexact_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      sgn_q     <= sgn_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      data_q    <= data_d;
      inexact_q <= inexact_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_data    = data_q;
  assign bus.out_inexact = inexact_q;

endmodule

// File: tb/tb_int_to_fp32.sv
// Self-checking bench: directed cases on SHIFT_STEP=1 plus a random sweep over
// SHIFT_STEP 1/2/4/8 against an arithmetic integer-to-float reference.
module tb_int_to_fp32;

  localparam int NUM_DUT   = 4;
  localparam int LAT_LIMIT = 100;
  localparam int OPS       = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_DUT-1:0] in_valid;
  logic [NUM_DUT-1:0] out_ready;
  logic [31:0]        in_data [NUM_DUT];
  wire  [NUM_DUT-1:0] in_ready;
  wire  [NUM_DUT-1:0] out_valid;
  wire  [NUM_DUT-1:0] out_inexact;
  wire  [31:0]        out_data [NUM_DUT];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
    int_to_fp32_if bus ();
    assign bus.in_valid    = in_valid[g];
    assign bus.in_data     = in_data[g];
    assign bus.out_ready   = out_ready[g];
    assign in_ready[g]     = bus.in_ready;
    assign out_valid[g]    = bus.out_valid;
    assign out_inexact[g]  = bus.out_inexact;
    assign out_data[g]     = bus.out_data;

    int_to_fp32 #(.SHIFT_STEP(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int msb_pos(input longint m);
    int p = 0;
    for (int i = 0; i < 40; i++) if (m[i]) p = i;
    return p;
  endfunction

  function automatic longint abs_of(input logic [31:0] x);
    longint m = longint'($signed(x));
    return (m < 0) ? -m : m;
  endfunction

  // Returns {inexact, fp32}: exact scaling of |x|, then ties-to-even on the remainder.
  function automatic logic [32:0] ref_fp32(input logic [31:0] x);
    longint m, q, rem, half;
    int     p, e, sh;
    m = abs_of(x);
    if (m == 0) return 33'd0;
    p   = msb_pos(m);
    e   = 127 + p;
    rem = 0;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {rem != 0, x[31], e[7:0], q[22:0]};
  endfunction

  // Edges after the acceptance edge until out_valid is seen (zero is visible right after it).
  function automatic int ref_latency(input logic [31:0] x, input int step);
    longint m = abs_of(x);
    int lz;
    if (m == 0) return 0;
    lz = 31 - msb_pos(m);
    return 2 + (lz + step - 1) / step;
  endfunction

  task automatic convert(input int d, input logic [31:0] x,
                         output logic [31:0] data, output logic inexact, output int lat);
    @(negedge clk);
    in_valid[d]  = 1'b1;
    in_data[d]   = x;
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1 lat++;
    end
    check($sformatf("out_valid_seen d%0d x=%h", d, x), {31'b0, out_valid[d]}, 32'd1);
    data    = out_data[d];
    inexact = out_inexact[d];
    @(posedge clk);
    #1 check($sformatf("idle_after d%0d x=%h", d, x), {30'b0, in_ready[d], out_valid[d]}, 32'b10);
  endtask

  task automatic directed(input string name, input logic [31:0] x, input logic [31:0] exp_data,
                          input logic exp_inexact, input int exp_lat);
    logic [31:0] data;
    logic        inexact;
    int          lat;
    convert(0, x, data, inexact, lat);
    check({name, " data"}, data, exp_data);
    check({name, " inexact"}, {31'b0, inexact}, {31'b0, exp_inexact});
    if (exp_lat >= 0) check({name, " latency"}, lat, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    logic [31:0] x, data;
    logic [32:0] model;
    logic        inexact, seen;
    int          lat;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < NUM_DUT; i++) in_data[i] = 32'h0;

    #12;
    check("reset in_ready", {28'b0, in_ready}, 32'hF);
    check("reset out_valid", {28'b0, out_valid}, 32'h0);
    check("reset out_inexact", {28'b0, out_inexact}, 32'h0);
    for (int i = 0; i < NUM_DUT; i++) check($sformatf("reset out_data d%0d", i), out_data[i], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("one",       32'd1,        32'h3F800000, 1'b0, 33);
    directed("minus_one", 32'hFFFFFFFF, 32'hBF800000, 1'b0, 33);
    directed("zero",      32'd0,        32'h00000000, 1'b0, 0);
    directed("int_min",   32'h80000000, 32'hCF000000, 1'b0, 2);
    directed("int_max",   32'h7FFFFFFF, 32'h4F000000, 1'b1, 3);
    directed("tie_down",  32'd16777217, 32'h4B800000, 1'b1, -1);
    directed("tie_up",    32'd16777219, 32'h4B800002, 1'b1, -1);
    directed("tie_even",  32'd16777221, 32'h4B800002, 1'b1, -1);

    // Backpressure: result must hold while the consumer stalls; new operands are ignored.
    @(negedge clk);
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'd100;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1 lat++;
    end
    check("bp latency", lat, 27);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("bp hold out_valid %0d", i), {31'b0, out_valid[0]}, 32'd1);
      check($sformatf("bp hold out_data %0d", i), out_data[0], 32'h42C80000);
      check($sformatf("bp hold in_ready %0d", i), {31'b0, in_ready[0]}, 32'd0);
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 check("bp release", {30'b0, in_ready[0], out_valid[0]}, 32'b10);
    repeat (3) begin
      @(posedge clk);
      #1 check("bp single transfer", {30'b0, in_ready[0], out_valid[0]}, 32'b10);
    end

    // Asynchronous reset in the middle of normalising operand 1.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'd1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort in_ready", {31'b0, in_ready[0]}, 32'd1);
    check("abort out_valid", {31'b0, out_valid[0]}, 32'd0);
    check("abort out_data", out_data[0], 32'h0);
    check("abort out_inexact", {31'b0, out_inexact[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid[0]) seen = 1'b1;
    end
    check("abort no stale output", {31'b0, seen}, 32'd0);
    directed("five_after_reset", 32'd5, 32'h40A00000, 1'b0, 31);

    // Random sweep over every SHIFT_STEP instance, spreading leading-zero counts evenly.
    for (int d = 0; d < NUM_DUT; d++) begin
      for (int n = 0; n < OPS; n++) begin
        x = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) x = -x;
        if ($urandom_range(0, 63) == 0) x = 32'd0;
        model = ref_fp32(x);
        convert(d, x, data, inexact, lat);
        check($sformatf("rand data step%0d x=%h", 1 << d, x), data, model[31:0]);
        check($sformatf("rand inexact step%0d x=%h", 1 << d, x), {31'b0, inexact}, {31'b0, model[32]});
        check($sformatf("rand latency step%0d x=%h", 1 << d, x), lat, ref_latency(x, 1 << d));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
